spec_return_stack: RTL and testbench

Parametrised speculative return address stack for the fetch-stage branch predictor. It pushes return addresses on predicted calls and pops them on predicted returns. A FIFO-ordered checkpoint ring snapshots stack state at each predicted branch, so that a backend mispredict can restore the stack exactly. It sits beside the BTB and target cache and feeds the next-PC mux with `top_addr`.

---
 rtl/spec_return_stack.sv | 213 +++++++++++++++++++++
 tb/tb_spec_return_stack.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spec_return_stack.sv
// Speculative return address stack with a FIFO-ordered checkpoint ring for mispredict restore.
// Latency: top_addr/top_valid follow a push/pop one cycle later; ckpt_ack/ckpt_tag are same-cycle.
// Backpressure: none on push/pop; ckpt_req is refused (ack low) while the ring is full or a recover is active.
// Optional: define RAS_PERF_CNT_EN to add saturating overflow/underflow counters (o_ovf_cnt, o_unf_cnt).
module spec_return_stack #(
    parameter int  DEPTH = 8,
    parameter int  AW    = 32,
    parameter int  CKPT  = 4,
    localparam int TW    = $clog2(CKPT)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_push_valid,
    input  logic [AW-1:0] i_push_addr,
    input  logic          i_pop_valid,
    output logic [AW-1:0] o_top_addr,
    output logic          o_top_valid,
    input  logic          i_ckpt_req,
    output logic          o_ckpt_ack,
    output logic [TW-1:0] o_ckpt_tag,
    output logic          o_ckpt_full,
    input  logic          i_recover_valid,
    input  logic [TW-1:0] i_recover_tag,
    input  logic          i_release_valid,
    input  logic [TW-1:0] i_release_tag
`ifdef RAS_PERF_CNT_EN
    ,
    output logic [15:0]   o_ovf_cnt,
    output logic [15:0]   o_unf_cnt
`endif
);

    localparam int SPW = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int UW  = TW + 1;
    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
    localparam logic [UW-1:0] L_CKPT  = UW'(CKPT);

    // Stack storage and pointers
    logic [AW-1:0]  r_stack [DEPTH];
    logic [SPW-1:0] r_sp;
    logic [CW-1:0]  r_count;

    // Checkpoint ring: snapshot of {sp, count, top} per slot
    logic [SPW-1:0] r_ck_sp  [CKPT];
    logic [CW-1:0]  r_ck_cnt [CKPT];
    logic [AW-1:0]  r_ck_top [CKPT];
    logic [TW-1:0]  r_head;
    logic [TW-1:0]  r_tail;
    logic [UW-1:0]  r_used;

    logic [SPW-1:0] w_sp_m1;
    logic [SPW-1:0] w_sp_m2;
    logic           w_nonempty;
    logic           w_full_stk;
    logic           w_do_push;
    logic           w_do_pop;
    logic [SPW-1:0] w_sp_nxt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [AW-1:0]  w_top_nxt;
    logic           w_wr_en;
    logic [SPW-1:0] w_wr_idx;
    logic           w_ovf;
    logic           w_unf;
    logic           w_ack;
    logic           w_rel;
    logic [TW-1:0]  w_head_nxt;
    logic [SPW-1:0] w_rc_sp;
    logic [CW-1:0]  w_rc_cnt;
    logic [AW-1:0]  w_rc_top;
    logic [SPW-1:0] w_rc_sp_m1;

    assign w_sp_m1    = r_sp - SPW'(1);
    assign w_sp_m2    = r_sp - SPW'(2);
    assign w_nonempty = (r_count != '0);
    assign w_full_stk = (r_count == L_DEPTH);
    // A recover squashes any same-cycle push/pop.
    assign w_do_push  = i_push_valid & ~i_recover_valid;
    assign w_do_pop   = i_pop_valid & ~i_recover_valid;

    assign o_top_addr  = r_stack[w_sp_m1];
    assign o_top_valid = w_nonempty;
    assign o_ckpt_full = (r_used == L_CKPT);
    assign o_ckpt_tag  = r_tail;
    assign w_ack       = i_ckpt_req & ~o_ckpt_full & ~i_recover_valid;
    assign o_ckpt_ack  = w_ack;

    // Release only retires a live head slot; an empty ring ignores it.
    assign w_rel      = i_release_valid & (i_release_tag == r_head) & (r_used != '0);
    assign w_head_nxt = r_head + TW'(w_rel);

    assign w_rc_sp    = r_ck_sp[i_recover_tag];
    assign w_rc_cnt   = r_ck_cnt[i_recover_tag];
    assign w_rc_top   = r_ck_top[i_recover_tag];
    assign w_rc_sp_m1 = w_rc_sp - SPW'(1);

    // Next stack pointer/count, write target and post-update top for the checkpoint snapshot
    always_comb begin
        w_sp_nxt  = r_sp;
        w_cnt_nxt = r_count;
        w_top_nxt = r_stack[w_sp_m1];
        w_wr_en   = 1'b0;
        w_wr_idx  = r_sp;
        w_ovf     = 1'b0;
        w_unf     = 1'b0;
        if (w_do_push && w_do_pop && w_nonempty) begin
            // Replace the top in place: a return immediately followed by a call.
            w_wr_en   = 1'b1;
            w_wr_idx  = w_sp_m1;
            w_top_nxt = i_push_addr;
        end else if (w_do_push) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = r_sp;
            w_sp_nxt  = r_sp + SPW'(1);
            w_cnt_nxt = w_full_stk ? r_count : r_count + CW'(1);
            w_ovf     = w_full_stk;
            w_top_nxt = i_push_addr;
        end else if (w_do_pop) begin
            if (w_nonempty) begin
                w_sp_nxt  = w_sp_m1;
                w_cnt_nxt = r_count - CW'(1);
                w_top_nxt = (r_count >= CW'(2)) ? r_stack[w_sp_m2] : r_stack[w_sp_m1];
            end else begin
                w_unf = 1'b1;
            end
        end
    end

    // Stack entry writes: restore the saved top on recover, else the push data
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
        end else if (i_recover_valid) begin
            if (w_rc_cnt != '0) r_stack[w_rc_sp_m1] <= w_rc_top;
        end else if (w_wr_en) begin
            r_stack[w_wr_idx] <= i_push_addr;
        end
    end

    // Stack pointer and occupancy
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sp    <= '0;
            r_count <= '0;
        end else if (i_recover_valid) begin
            r_sp    <= w_rc_sp;
            r_count <= w_rc_cnt;
        end else begin
            r_sp    <= w_sp_nxt;
            r_count <= w_cnt_nxt;
        end
    end

    // Checkpoint ring allocation, release and recover truncation
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < CKPT; i++) begin
                r_ck_sp[i]  <= '0;
                r_ck_cnt[i] <= '0;
                r_ck_top[i] <= '0;
            end
            r_head <= '0;
            r_tail <= '0;
            r_used <= '0;
        end else begin
            r_head <= w_head_nxt;
            if (i_recover_valid) begin
                if (w_rel && (i_recover_tag == r_head)) begin
                    // Recovering to the slot just retired leaves nothing live.
                    r_tail <= w_head_nxt;
                    r_used <= '0;
                end else begin
                    r_tail <= i_recover_tag;
                    r_used <= {1'b0, i_recover_tag - w_head_nxt};
                end
            end else begin
                if (w_ack) begin
                    r_ck_sp[r_tail]  <= w_sp_nxt;
                    r_ck_cnt[r_tail] <= w_cnt_nxt;
                    r_ck_top[r_tail] <= w_top_nxt;
                    r_tail           <= r_tail + TW'(1);
                end
                case ({w_ack, w_rel})
                    2'b10:   r_used <= r_used + UW'(1);
                    2'b01:   r_used <= r_used - UW'(1);
                    default: r_used <= r_used;
                endcase
            end
        end
    end

`ifdef RAS_PERF_CNT_EN
    logic [15:0] r_ovf_cnt;
    logic [15:0] r_unf_cnt;

    // Saturating counts of overflowing pushes and underflowing pops
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ovf_cnt <= '0;
            r_unf_cnt <= '0;
        end else begin
            if (w_ovf && (r_ovf_cnt != 16'hFFFF)) r_ovf_cnt <= r_ovf_cnt + 16'd1;
            if (w_unf && (r_unf_cnt != 16'hFFFF)) r_unf_cnt <= r_unf_cnt + 16'd1;
        end
    end

    assign o_ovf_cnt = r_ovf_cnt;
    assign o_unf_cnt = r_unf_cnt;
`else
    // Counters are not built; overflow/underflow are silent.
`endif

endmodule

// File: tb/tb_spec_return_stack.sv
// Self-checking bench for spec_return_stack: directed scenarios plus randomized traffic against a reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too, ack/tag just before the edge.
// The model keeps the stack as a circular array with sp/count and a list of {sp,count,top} checkpoints.
module tb_spec_return_stack;

    localparam int DEPTH = 8;
    localparam int AW    = 32;
    localparam int CKPT  = 4;
    localparam int TW    = 2;

    logic          clk = 1'b0;
    logic          resetn;
    logic          push_valid;
    logic [AW-1:0] push_addr;
    logic          pop_valid;
    logic [AW-1:0] top_addr;
    logic          top_valid;
    logic          ckpt_req;
    logic          ckpt_ack;
    logic [TW-1:0] ckpt_tag;
    logic          ckpt_full;
    logic          recover_valid;
    logic [TW-1:0] recover_tag;
    logic          release_valid;
    logic [TW-1:0] release_tag;
`ifdef RAS_PERF_CNT_EN
    logic [15:0]   ovf_cnt;
    logic [15:0]   unf_cnt;
`endif

    always #5 clk = ~clk;

    spec_return_stack #(.DEPTH(DEPTH), .AW(AW), .CKPT(CKPT)) dut (
        .clk(clk),
        .resetn(resetn),
        .i_push_valid(push_valid),
        .i_push_addr(push_addr),
        .i_pop_valid(pop_valid),
        .o_top_addr(top_addr),
        .o_top_valid(top_valid),
        .i_ckpt_req(ckpt_req),
        .o_ckpt_ack(ckpt_ack),
        .o_ckpt_tag(ckpt_tag),
        .o_ckpt_full(ckpt_full),
        .i_recover_valid(recover_valid),
        .i_recover_tag(recover_tag),
        .i_release_valid(release_valid),
        .i_release_tag(release_tag)
`ifdef RAS_PERF_CNT_EN
        ,
        .o_ovf_cnt(ovf_cnt),
        .o_unf_cnt(unf_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [AW-1:0] m_stk [DEPTH];
    int            m_sp, m_cnt;
    int            ck_sp [CKPT];
    int            ck_cnt [CKPT];
    logic [AW-1:0] ck_top [CKPT];
    int            m_head, m_tail, m_used;
    int            m_ovf, m_unf;

    // Values captured before the edge of the last cycle
    logic          obs_ack;
    logic [TW-1:0] obs_tag;
    logic          exp_ack;
    logic [TW-1:0] exp_tag;

    function automatic logic [AW-1:0] m_top();
        return m_stk[(m_sp + DEPTH - 1) % DEPTH];
    endfunction

    task automatic model_update();
        int rel_ok, new_head, s, c, n_sp, n_cnt, rt;
        logic [AW-1:0] tn;
        logic ack;
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) m_stk[i] = '0;
            m_sp = 0; m_cnt = 0; m_head = 0; m_tail = 0; m_used = 0; m_ovf = 0; m_unf = 0;
            return;
        end
        rel_ok   = (release_valid && int'(release_tag) == m_head && m_used > 0) ? 1 : 0;
        new_head = (m_head + rel_ok) % CKPT;
        if (recover_valid) begin
            rt = int'(recover_tag);
            s = ck_sp[rt]; c = ck_cnt[rt];
            if (c > 0) m_stk[(s + DEPTH - 1) % DEPTH] = ck_top[rt];
            m_sp = s; m_cnt = c;
            if (rel_ok == 1 && rt == m_head) begin
                m_tail = new_head; m_used = 0;
            end else begin
                m_tail = rt; m_used = (rt - new_head + CKPT) % CKPT;
            end
            m_head = new_head;
            return;
        end
        ack = ckpt_req && (m_used < CKPT);
        n_sp = m_sp; n_cnt = m_cnt; tn = m_top();
        if (push_valid && pop_valid && m_cnt > 0) begin
            m_stk[(m_sp + DEPTH - 1) % DEPTH] = push_addr;
            tn = push_addr;
        end else if (push_valid) begin
            if (m_cnt == DEPTH && m_ovf < 65535) m_ovf++;
            m_stk[m_sp] = push_addr;
            n_sp  = (m_sp + 1) % DEPTH;
            n_cnt = (m_cnt == DEPTH) ? DEPTH : m_cnt + 1;
            tn    = push_addr;
        end else if (pop_valid) begin
            if (m_cnt > 0) begin
                if (m_cnt >= 2) tn = m_stk[(m_sp + DEPTH - 2) % DEPTH];
                n_sp  = (m_sp + DEPTH - 1) % DEPTH;
                n_cnt = m_cnt - 1;
            end else if (m_unf < 65535) begin
                m_unf++;
            end
        end
        m_sp = n_sp; m_cnt = n_cnt;
        if (ack) begin
            ck_sp[m_tail] = n_sp; ck_cnt[m_tail] = n_cnt; ck_top[m_tail] = tn;
            m_tail = (m_tail + 1) % CKPT;
            m_used++;
        end
        if (rel_ok == 1) begin
            m_head = new_head;
            m_used--;
        end
    endtask

    // One clock: capture combinational outputs, clock the DUT and the model, settle.
    task automatic cycle();
        int t;
        #1;
        obs_ack = ckpt_ack;
        obs_tag = ckpt_tag;
        exp_ack = ckpt_req && (m_used < CKPT) && !recover_valid;
        t = m_tail;
        exp_tag = t[TW-1:0];
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        push_valid = 0; push_addr = '0; pop_valid = 0; ckpt_req = 0;
        recover_valid = 0; recover_tag = '0; release_valid = 0; release_tag = '0;
    endtask

    task automatic do_op(input logic psh, input logic [AW-1:0] a, input logic pp, input logic rq,
                         input logic rc, input logic [TW-1:0] rct, input logic rl, input logic [TW-1:0] rlt);
        push_valid = psh; push_addr = a; pop_valid = pp; ckpt_req = rq;
        recover_valid = rc; recover_tag = rct; release_valid = rl; release_tag = rlt;
        cycle();
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 0;
        cycle();
        resetn = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 0;
        cycle();
        cycle();
        checks++; if (top_addr !== '0) begin errors++; $display("FAIL reset_top: got %h want 0", top_addr); end
        checks++; if (top_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", top_valid); end
        checks++; if (ckpt_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", ckpt_full); end
        checks++; if (ckpt_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ckpt_ack); end
        checks++; if (ckpt_tag !== '0) begin errors++; $display("FAIL reset_tag: got %0d want 0", ckpt_tag); end
        resetn = 1;
    endtask

    task automatic test_push_pop();
        logic [AW-1:0] exp_t;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            exp_t = AW'(i * 32'h100);
            do_op(1, exp_t, 0, 0, 0, 0, 0, 0);
            checks++; if (top_addr !== exp_t) begin errors++; $display("FAIL push_top%0d: got %h want %h", i, top_addr, exp_t); end
        end
        for (int i = 0; i < 3; i++) begin
            do_op(0, 0, 1, 0, 0, 0, 0, 0);
            checks++;
            if (top_valid !== (i < 2)) begin errors++; $display("FAIL pop_valid%0d: got %b want %b", i, top_valid, (i < 2)); end
        end
        do_op(0, 0, 1, 0, 0, 0, 0, 0);
        do_op(1, 32'hAA, 0, 0, 0, 0, 0, 0);
        checks++; if (top_addr !== 32'hAA || top_valid !== 1'b1) begin errors++; $display("FAIL underflow_push: got %h/%b want 000000aa/1", top_addr, top_valid); end
`ifdef RAS_PERF_CNT_EN
        checks++; if (unf_cnt !== 16'd1) begin errors++; $display("FAIL unf_cnt: got %0d want 1", unf_cnt); end
`endif
        do_op(0, 0, 1, 0, 0, 0, 0, 0);
        checks++; if (top_valid !== 1'b0) begin errors++; $display("FAIL underflow_count: got %b want 0", top_valid); end
    endtask

    task automatic test_overflow();
        logic [AW-1:0] exp_t;
        do_reset();
        for (int i = 1; i <= 9; i++) do_op(1, AW'(i * 16), 0, 0, 0, 0, 0, 0);
        checks++; if (top_addr !== 32'h90 || top_valid !== 1'b1) begin errors++; $display("FAIL ovf_top: got %h/%b want 00000090/1", top_addr, top_valid); end
`ifdef RAS_PERF_CNT_EN
        checks++; if (ovf_cnt !== 16'd1) begin errors++; $display("FAIL ovf_cnt: got %0d want 1", ovf_cnt); end
`endif
        for (int i = 0; i < 8; i++) begin
            exp_t = AW'(32'h90 - 16 * i);
            checks++; if (top_addr !== exp_t) begin errors++; $display("FAIL ovf_pop%0d: got %h want %h", i, top_addr, exp_t); end
            do_op(0, 0, 1, 0, 0, 0, 0, 0);
        end
        checks++; if (top_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", top_valid); end
    endtask

    task automatic test_push_pop_same();
        do_reset();
        do_op(1, 32'hA0, 0, 0, 0, 0, 0, 0);
        do_op(1, 32'hB0, 1, 0, 0, 0, 0, 0);
        checks++; if (top_addr !== 32'hB0) begin errors++; $display("FAIL pp_top: got %h want 000000b0", top_addr); end
        do_op(0, 0, 1, 0, 0, 0, 0, 0);
        checks++; if (top_valid !== 1'b0) begin errors++; $display("FAIL pp_count: got %b want 0", top_valid); end
        do_op(1, 32'hC0, 1, 0, 0, 0, 0, 0);
        checks++; if (top_addr !== 32'hC0 || top_valid !== 1'b1) begin errors++; $display("FAIL pp_empty: got %h/%b want 000000c0/1", top_addr, top_valid); end
        do_op(0, 0, 1, 0, 0, 0, 0, 0);
        checks++; if (top_valid !== 1'b0) begin errors++; $display("FAIL pp_empty_count: got %b want 0", top_valid); end
    endtask

    task automatic test_recover();
        do_reset();
        do_op(1, 32'h400, 0, 0, 0, 0, 0, 0);
        do_op(0, 0, 0, 1, 0, 0, 0, 0);
        checks++; if (obs_ack !== 1'b1 || obs_tag !== 2'd0) begin errors++; $display("FAIL rec_ckpt: got ack %b tag %0d want 1/0", obs_ack, obs_tag); end
        do_op(0, 0, 1, 0, 0, 0, 0, 0);
        do_op(1, 32'h500, 0, 0, 0, 0, 0, 0);
        do_op(1, 32'h600, 0, 0, 0, 0, 0, 0);
        checks++; if (top_addr !== 32'h600) begin errors++; $display("FAIL rec_pre: got %h want 00000600", top_addr); end
        do_op(1, 32'h777, 0, 1, 1, 0, 0, 0);
        checks++; if (obs_ack !== 1'b0) begin errors++; $display("FAIL rec_ack_suppress: got %b want 0", obs_ack); end
        checks++; if (top_addr !== 32'h400 || top_valid !== 1'b1) begin errors++; $display("FAIL rec_top: got %h/%b want 00000400/1", top_addr, top_valid); end
        checks++; if (ckpt_tag !== 2'd0 || ckpt_full !== 1'b0) begin errors++; $display("FAIL rec_ring: got tag %0d full %b want 0/0", ckpt_tag, ckpt_full); end
        do_op(0, 0, 1, 0, 0, 0, 0, 0);
        checks++; if (top_valid !== 1'b0) begin errors++; $display("FAIL rec_count: got %b want 0", top_valid); end
    endtask

    task automatic test_ckpt_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_op(0, 0, 0, 1, 0, 0, 0, 0);
            checks++; if (obs_ack !== 1'b1 || obs_tag !== TW'(i)) begin errors++; $display("FAIL full_grant%0d: got ack %b tag %0d want 1/%0d", i, obs_ack, obs_tag, i); end
        end
        checks++; if (ckpt_full !== 1'b1) begin errors++; $display("FAIL full_set: got %b want 1", ckpt_full); end
        do_op(0, 0, 0, 1, 0, 0, 0, 0);
        checks++; if (obs_ack !== 1'b0) begin errors++; $display("FAIL full_refuse: got %b want 0", obs_ack); end
        do_op(0, 0, 0, 0, 0, 0, 1, 2'd2);
        checks++; if (ckpt_full !== 1'b1) begin errors++; $display("FAIL full_bad_release: got %b want 1", ckpt_full); end
        do_op(0, 0, 0, 0, 0, 0, 1, 2'd0);
        checks++; if (ckpt_full !== 1'b0) begin errors++; $display("FAIL full_release: got %b want 0", ckpt_full); end
        do_op(0, 0, 0, 1, 0, 0, 0, 0);
        checks++; if (obs_ack !== 1'b1 || obs_tag !== 2'd0) begin errors++; $display("FAIL full_regrant: got ack %b tag %0d want 1/0", obs_ack, obs_tag); end
    endtask

    task automatic test_release_recover();
        do_reset();
        do_op(1, 32'h11, 0, 1, 0, 0, 0, 0);
        do_op(1, 32'h22, 0, 1, 0, 0, 0, 0);
        do_op(1, 32'h33, 0, 1, 0, 0, 0, 0);
        do_op(1, 32'h44, 0, 0, 0, 0, 0, 0);
        do_op(0, 0, 0, 0, 1, 2'd1, 1, 2'd0);
        checks++; if (top_addr !== 32'h22 || top_valid !== 1'b1) begin errors++; $display("FAIL rr_top: got %h/%b want 00000022/1", top_addr, top_valid); end
        checks++; if (ckpt_tag !== 2'd1 || ckpt_full !== 1'b0) begin errors++; $display("FAIL rr_ring: got tag %0d full %b want 1/0", ckpt_tag, ckpt_full); end
        for (int i = 0; i < 4; i++) begin
            do_op(0, 0, 0, 1, 0, 0, 0, 0);
            checks++; if (obs_ack !== 1'b1 || obs_tag !== TW'(i + 1)) begin errors++; $display("FAIL rr_grant%0d: got ack %b tag %0d want 1/%0d", i, obs_ack, obs_tag, (i + 1) % 4); end
        end
        checks++; if (ckpt_full !== 1'b1) begin errors++; $display("FAIL rr_full: got %b want 1", ckpt_full); end
        do_op(0, 0, 1, 0, 0, 0, 0, 0);
        checks++; if (top_addr !== 32'h11) begin errors++; $display("FAIL rr_pop: got %h want 00000011", top_addr); end
        do_op(0, 0, 1, 0, 0, 0, 0, 0);
        checks++; if (top_valid !== 1'b0) begin errors++; $display("FAIL rr_empty: got %b want 0", top_valid); end
    endtask

    task automatic test_random();
        int bad;
        logic [TW-1:0] ht;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            resetn     = ($urandom_range(0, 299) != 0);
            push_valid = ($urandom_range(0, 2) == 0);
            push_addr  = $urandom;
            pop_valid  = ($urandom_range(0, 2) == 0);
            ckpt_req   = ($urandom_range(0, 2) == 0);
            ht         = m_head[TW-1:0];
            recover_valid = (m_used > 0) && ($urandom_range(0, 15) == 0);
            recover_tag   = (m_used > 0) ? TW'((m_head + $urandom_range(0, m_used - 1)) % CKPT) : '0;
            release_valid = (m_used > 0) && ($urandom_range(0, 3) == 0);
            release_tag   = ($urandom_range(0, 7) == 0) ? TW'($urandom) : ht;
            cycle();
            bad = 0;
            checks++; if (obs_ack !== exp_ack) begin errors++; bad++; $display("FAIL rnd_ack@%0d: got %b want %b", n, obs_ack, exp_ack); end
            checks++; if (obs_tag !== exp_tag) begin errors++; bad++; $display("FAIL rnd_tag@%0d: got %0d want %0d", n, obs_tag, exp_tag); end
            checks++; if (top_addr !== m_top()) begin errors++; bad++; $display("FAIL rnd_top@%0d: got %h want %h", n, top_addr, m_top()); end
            checks++; if (top_valid !== (m_cnt != 0)) begin errors++; bad++; $display("FAIL rnd_valid@%0d: got %b want %b", n, top_valid, (m_cnt != 0)); end
            checks++; if (ckpt_full !== (m_used == CKPT)) begin errors++; bad++; $display("FAIL rnd_full@%0d: got %b want %b", n, ckpt_full, (m_used == CKPT)); end
`ifdef RAS_PERF_CNT_EN
            checks++; if (ovf_cnt !== 16'(m_ovf) || unf_cnt !== 16'(m_unf)) begin errors++; bad++; $display("FAIL rnd_perf@%0d: got %0d/%0d want %0d/%0d", n, ovf_cnt, unf_cnt, m_ovf, m_unf); end
`endif
            if (bad != 0) break;
        end
        idle_inputs();
        resetn = 1;
    endtask

    initial begin
        idle_inputs();
        resetn = 0;
        test_reset();
        test_push_pop();
        test_overflow();
        test_push_pop_same();
        test_recover();
        test_ckpt_full();
        test_release_recover();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
